// File: rtl/alu_pkg.sv
// Shared datapath definitions for the MIPS-subset pipeline: widths, ALU op codes,
// EX/MEM control bundle and the EX/MEM entry payload layout.
package alu_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluNor = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
  } exmem_ctrl_t;

  typedef struct packed {
    exmem_ctrl_t   ctrl;
    logic [RW-1:0] rd;
    logic [DW-1:0] store;
    logic [DW-1:0] res;
  } exmem_payload_t;

  localparam int unsigned PayloadW = $bits(exmem_payload_t);

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bus: input handshake + payload, output handshake + payload, redirect.
// master = surrounding pipeline, slave = the ex_mem_stage register.
interface ex_mem_stage_if;
  import alu_pkg::*;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] Res;
  logic          Zflag;
  logic [DW-1:0] StoreData;
  logic [RW-1:0] Rd;
  logic          RegWrite;
  logic          MemRead;
  logic          MemWrite;
  logic          Branch;
  logic          BranchNe;
  logic [DW-1:0] BranchTarget;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] AluOut;
  logic [DW-1:0] MemData;
  logic [RW-1:0] RdOut;
  logic          RegWriteOut;
  logic          MemReadOut;
  logic          MemWriteOut;
  logic          Redirect;
  logic [DW-1:0] RedirectPC;

  modport master (
    output flush, in_valid, Res, Zflag, StoreData, Rd, RegWrite, MemRead, MemWrite,
           Branch, BranchNe, BranchTarget, out_ready,
    input  in_ready, out_valid, AluOut, MemData, RdOut, RegWriteOut, MemReadOut,
           MemWriteOut, Redirect, RedirectPC
  );

  modport slave (
    input  flush, in_valid, Res, Zflag, StoreData, Rd, RegWrite, MemRead, MemWrite,
           Branch, BranchNe, BranchTarget, out_ready,
    output in_ready, out_valid, AluOut, MemData, RdOut, RegWriteOut, MemReadOut,
           MemWriteOut, Redirect, RedirectPC
  );

endinterface

// File: rtl/exmem_entry.sv
// One payload register with a valid bit. Clear wins over load and only drops valid,
// so the data field keeps its stale contents.
module exmem_entry
  import alu_pkg::*;
#(
  parameter int unsigned W = PayloadW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with BEQ/BNE resolution and one-cycle fetch redirect.
// Define EXMEM_SKID_EN for a two-entry skid buffer with registered in_ready.
module ex_mem_stage
  import alu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  logic           w_accept;
  logic           w_drain;
  logic           w_taken;
  logic           w_main_load;
  logic           w_main_clear;
  logic           w_main_valid;
  exmem_payload_t w_in_payload;
  exmem_payload_t w_main_next;
  exmem_payload_t w_main_data;
  logic           r_redirect;
  logic [DW-1:0]  r_redirect_pc;

  // Branches travel as bubbles so MEM/WB never act on them.
  always_comb begin
    w_in_payload.ctrl.RegWrite = bus.RegWrite & ~bus.Branch;
    w_in_payload.ctrl.MemRead  = bus.MemRead & ~bus.Branch;
    w_in_payload.ctrl.MemWrite = bus.MemWrite & ~bus.Branch;
    w_in_payload.rd            = bus.Rd;
    w_in_payload.store         = bus.StoreData;
    w_in_payload.res           = bus.Res;
  end

  assign w_taken = bus.Branch & (bus.BranchNe ? ~bus.Zflag : bus.Zflag);
  assign w_drain = w_main_valid & bus.out_ready;

`ifdef EXMEM_SKID_EN
  logic           w_skid_valid;
  logic           w_skid_load;
  logic           w_skid_clear;
  exmem_payload_t w_skid_data;

  assign bus.in_ready = ~w_skid_valid;
  assign w_accept     = bus.in_valid & ~w_skid_valid & ~bus.flush;
  // Skid is only ever occupied behind a valid main entry, and refills main first.
  assign w_main_load  = (~w_main_valid | w_drain) & (w_skid_valid | w_accept);
  assign w_main_next  = w_skid_valid ? w_skid_data : w_in_payload;
  assign w_main_clear = bus.flush | (w_drain & ~w_skid_valid & ~w_accept);
  assign w_skid_load  = w_accept & w_main_valid & ~w_drain;
  assign w_skid_clear = bus.flush | (w_drain & w_skid_valid);

  exmem_entry #(.W(PayloadW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_payload),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );
`else
  assign bus.in_ready = ~w_main_valid | bus.out_ready;
  assign w_accept     = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_main_load  = w_accept;
  assign w_main_next  = w_in_payload;
  assign w_main_clear = bus.flush | (w_drain & ~w_accept);
`endif

  exmem_entry #(.W(PayloadW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_next),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  // Accept is already gated by flush, so a flush cycle never raises Redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_accept & w_taken;
      if (w_accept & w_taken) begin
        r_redirect_pc <= bus.BranchTarget;
      end
    end
  end

  assign bus.out_valid   = w_main_valid;
  assign bus.AluOut      = w_main_data.res;
  assign bus.MemData     = w_main_data.store;
  assign bus.RdOut       = w_main_data.rd;
  assign bus.RegWriteOut = w_main_data.ctrl.RegWrite;
  assign bus.MemReadOut  = w_main_data.ctrl.MemRead;
  assign bus.MemWriteOut = w_main_data.ctrl.MemWrite;
  assign bus.Redirect    = r_redirect;
  assign bus.RedirectPC  = r_redirect_pc;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute stage (ALU) and the memory stage of the MIPS-subset datapath. It captures the ALU result, the zero flag, the store data, the destination register and the memory/writeback control bits under a valid/ready handshake. It also resolves BEQ/BNE from the zero flag and issues a one-cycle fetch redirect. Holds data across memory-stage stalls and drops it on pipeline flush.

## Interface
- DW, 32, datapath width (ALU result, store data, PC)
- RW, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held entries and the current input
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage accepts this cycle
- Res  in  DW  ALU result
- Zflag  in  1  ALU zero flag
- StoreData  in  DW  rt value for SW
- Rd  in  RW  destination register
- RegWrite, MemRead, MemWrite  in  1 each  downstream controls
- Branch, BranchNe  in  1 each  BEQ when Branch&~BranchNe, BNE when Branch&BranchNe
- BranchTarget  in  DW  precomputed PC+4+(imm<<2)
- out_valid  out  1  MEM-stage entry valid
- out_ready  in  1  MEM stage consumes this cycle
- AluOut, MemData  out  DW each  registered Res, StoreData
- RdOut  out  RW; RegWriteOut, MemReadOut, MemWriteOut  out  1 each
- Redirect  out  1  one-cycle taken-branch pulse
- RedirectPC  out  DW  target, valid while Redirect=1

## Operation
- Accept when in_valid & in_ready & ~flush; transfer out when out_valid & out_ready.
- taken = Branch & (BranchNe ? ~Zflag : Zflag), evaluated on the accepted beat only.
- Branches enter the pipe as bubbles: the entry has RegWriteOut=MemReadOut=MemWriteOut=0, but out_valid still rises so ordering holds.
- Redirect/RedirectPC: registered the cycle after a taken accept, independent of out_ready. The stage does not flush itself; the front end asserts flush.
- flush: clears all entry valid bits and Redirect at the next edge; the input that cycle is not accepted; data fields keep stale values.
- Simultaneous accept and drain on a full single entry: new data replaces old with no bubble.
- Mid-operation rst: immediate clear; any pending redirect is lost.
- Controls are invalid when out_valid=0; MEM must gate on out_valid.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Reset values: out_valid=0, Redirect=0, RedirectPC=0, AluOut=MemData=0, RdOut=0, all control outputs 0. in_ready=1 once rst deasserts.
- Throughput: 1 per cycle while out_ready=1.
- Outputs are register-driven. in_ready depends on configuration (below).

## Configuration
- EXMEM_SKID_EN defined: two-entry skid buffer. in_ready is a register, equal to ~(skid entry occupied). When out_ready drops, one further beat is absorbed into the skid entry. Drain order is main then skid. Full = both entries occupied.
- Undefined: single entry, combinational in_ready = ~out_valid | out_ready.
- Interface, reset and branch behaviour are identical in both builds.

## Structure
- Shared package alu_pkg: ALU op codes (ADD 4'b0010, AND 4'b0000, OR 4'b0001, SUB 4'b0110, NOR 4'b1100, SLT 4'b0111) and the packed struct exmem_ctrl_t {RegWrite, MemRead, MemWrite}. DW and RW defaults also live there.
- One sub-module, exmem_entry: a payload register with valid, load and clear. The main entry uses one instance, and the skid build adds a second.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> all outputs 0 immediately; in_ready=1 after release.
- Single beat: Res=0x0000_0005, Rd=3, RegWrite=1 accepted, out_ready=1 -> next cycle AluOut=5, RdOut=3, RegWriteOut=1, out_valid=1 for exactly one cycle.
- BEQ taken: Branch=1, BranchNe=0, Zflag=1, BranchTarget=0x0000_0040 -> Redirect=1 with RedirectPC=0x40 for one cycle; entry controls all 0. Same stimulus with Zflag=0 -> Redirect stays 0.
- BNE: Branch=1, BranchNe=1, Zflag=0, target 0x100 -> Redirect pulse with RedirectPC=0x100.
- Backpressure: hold out_ready=0 while feeding 0x11, 0x22, 0x33 -> SKID build accepts 0x11 and 0x22, then in_ready=0; non-skid build accepts 0x11 only. Releasing out_ready drains them in order with no loss or duplication.
- Flush: occupied entries plus in_valid=1 with flush=1 -> next cycle out_valid=0, Redirect=0, and the input is not captured.
